// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM states, port select,
// latched-request record and the address range check.
package dmem_arbiter_pkg;

    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        DARB_IDLE = 2'd0,
        DARB_ACC  = 2'd1,
        DARB_RESP = 2'd2
    } darbState_e;

    typedef enum logic {
        DARB_CPU = 1'b0,
        DARB_DBG = 1'b1
    } darbPort_e;

    // Per-access attributes held from grant until the response is issued.
    typedef struct packed {
        darbPort_e port;
        logic      we;
        logic      err;
    } darbLatch_t;

    // A quadword access must fit entirely inside the RAM; all 64 bits count.
    function automatic logic addrOob(input logic [ADDR_W-1:0] addr, input int memBytes);
        return addr > (64'(memBytes) - 64'd8);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester port (CPU or DBG) and RAM-side bus bundles for the data-RAM arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [63:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              stall;

    modport master (output req, we, addr, wdata, input rdata, done, err, stall);
    modport slave  (input req, we, addr, wdata, output rdata, done, err, stall);
endinterface

interface dmem_ram_if #(
    parameter int AW     = 10,
    parameter int DATA_W = 64
);
    logic              en;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of CPU grants taken while DBG waits; sat forces a DBG grant.
module dmem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(STARVE_MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

    assign sat = (cnt == W'(STARVE_MAX));
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM: IDLE -> ACC -> RESP,
// CPU priority with a starvation cap for the debug/loader port.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES  = 1024,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic           clk_i,
    input logic           rst_n_i,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave dbg,
    dmem_ram_if.master    ram
);
    localparam int AW = $clog2(MEM_BYTES);

    darbState_e state, stateNxt;
    logic       grantCpu, grantDbg, grant;
    logic       cntInc, cntClr, cntSat;

    logic              reqWe, reqErr;
    logic [63:0]       reqAddr;
    logic [DATA_W-1:0] reqWdata;

    darbLatch_t        lat;
    logic [AW-1:0]     addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              ramEnQ, ramWeQ;
    logic              cpuDoneQ, cpuErrQ, cpuRdQ;
    logic              dbgDoneQ, dbgErrQ, dbgRdQ;
    logic              inAcc;

    dmem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) uStarve (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (cntInc),
        .clr     (cntClr),
        .sat     (cntSat)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= DARB_IDLE;
        else          state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        grantCpu = 1'b0;
        grantDbg = 1'b0;
        cntInc   = 1'b0;
        cntClr   = 1'b0;
        unique case (state)
            DARB_IDLE: begin
                // CPU wins unless DBG has been passed over STARVE_MAX times in a row.
                if (dbg.req && (!cpu.req || cntSat)) grantDbg = 1'b1;
                else if (cpu.req)                    grantCpu = 1'b1;
                cntInc = grantCpu && dbg.req;
                cntClr = grantDbg || !dbg.req;
                if (grantCpu || grantDbg) stateNxt = DARB_ACC;
            end
            DARB_ACC: stateNxt = DARB_RESP;
            default:  stateNxt = DARB_IDLE;
        endcase
    end

    assign grant    = grantCpu || grantDbg;
    assign reqWe    = grantDbg ? dbg.we    : cpu.we;
    assign reqAddr  = grantDbg ? dbg.addr  : cpu.addr;
    assign reqWdata = grantDbg ? dbg.wdata : cpu.wdata;
    assign reqErr   = addrOob(reqAddr, MEM_BYTES);
    assign inAcc    = (state == DARB_ACC);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lat      <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            ramEnQ   <= 1'b0;
            ramWeQ   <= 1'b0;
            cpuDoneQ <= 1'b0;
            cpuErrQ  <= 1'b0;
            cpuRdQ   <= 1'b0;
            dbgDoneQ <= 1'b0;
            dbgErrQ  <= 1'b0;
            dbgRdQ   <= 1'b0;
        end else begin
            if (grant) begin
                lat.port <= grantDbg ? DARB_DBG : DARB_CPU;
                lat.we   <= reqWe;
                lat.err  <= reqErr;
                addrQ    <= reqAddr[AW-1:0];
                wdataQ   <= reqWdata;
            end
            // An out-of-range access still walks through ACC, just without touching the RAM.
            ramEnQ   <= grant && !reqErr;
            ramWeQ   <= grant && !reqErr && reqWe;
            cpuDoneQ <= inAcc && (lat.port == DARB_CPU);
            cpuErrQ  <= inAcc && (lat.port == DARB_CPU) && lat.err;
            cpuRdQ   <= inAcc && (lat.port == DARB_CPU) && !lat.we && !lat.err;
            dbgDoneQ <= inAcc && (lat.port == DARB_DBG);
            dbgErrQ  <= inAcc && (lat.port == DARB_DBG) && lat.err;
            dbgRdQ   <= inAcc && (lat.port == DARB_DBG) && !lat.we && !lat.err;
        end
    end

    assign ram.en    = ramEnQ;
    assign ram.we    = ramWeQ;
    assign ram.addr  = addrQ;
    assign ram.wdata = wdataQ;

    // RAM read data arrives in RESP itself, so it is gated by a registered select.
    assign cpu.rdata = cpuRdQ ? ram.rdata : '0;
    assign cpu.done  = cpuDoneQ;
    assign cpu.err   = cpuErrQ;
    assign cpu.stall = cpu.req && !cpuDoneQ;

    assign dbg.rdata = dbgRdQ ? ram.rdata : '0;
    assign dbg.done  = dbgDoneQ;
    assign dbg.err   = dbgErrQ;
    assign dbg.stall = dbg.req && !dbgDoneQ;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural quadword RAM.
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 1024;
    localparam int AW        = 10;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(64)) cpu ();
    dmem_arbiter_if #(.DATA_W(64)) dbg ();
    dmem_ram_if #(.AW(AW), .DATA_W(64)) ram ();

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .cpu     (cpu),
        .dbg     (dbg),
        .ram     (ram)
    );

    // Unwritten quadwords read back as their own byte address.
    logic [63:0]  mem [0:127];
    logic [127:0] wr = '0;
    logic [63:0]  ramQ = '0;
    always @(posedge clk) begin
        if (ram.en) begin
            if (ram.we) begin
                mem[ram.addr[AW-1:3]] <= ram.wdata;
                wr[ram.addr[AW-1:3]]  <= 1'b1;
            end else begin
                ramQ <= wr[ram.addr[AW-1:3]] ? mem[ram.addr[AW-1:3]] : 64'(ram.addr);
            end
        end
    end
    assign ram.rdata = ramQ;

    int nChk = 0;
    int nPass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge with the arbiter idle; returns one cycle after done.
    task automatic access(input bit isDbg, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rd,
                          output logic err, output int enCnt, output int lat,
                          output bit otherDone, output logic [63:0] enAddr,
                          output bit weSeen);
        if (isDbg) begin
            dbg.req = 1'b1; dbg.we = we; dbg.addr = addr; dbg.wdata = wdata;
        end else begin
            cpu.req = 1'b1; cpu.we = we; cpu.addr = addr; cpu.wdata = wdata;
        end
        enCnt = 0; lat = -1; otherDone = 1'b0; rd = 'x; err = 1'bx; enAddr = 'x; weSeen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ram.en) begin
                enCnt++;
                enAddr = 64'(ram.addr);
                weSeen = ram.we;
            end
            if (isDbg ? cpu.done : dbg.done) otherDone = 1'b1;
            if (isDbg ? dbg.done : cpu.done) begin
                lat = i;
                rd  = isDbg ? dbg.rdata : cpu.rdata;
                err = isDbg ? dbg.err : cpu.err;
                break;
            end
        end
        if (isDbg) begin
            dbg.req = 1'b0; dbg.we = 1'b0; dbg.addr = '0; dbg.wdata = '0;
        end else begin
            cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
        end
        @(negedge clk);
    endtask

    logic [63:0] rd, enAddr;
    logic        err;
    int          enCnt, lat;
    bit          otherDone, weSeen;

    initial begin
        cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
        dbg.req = 1'b0; dbg.we = 1'b0; dbg.addr = '0; dbg.wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ram_en",   64'(ram.en),   64'd0);
        chk("rst ram_we",   64'(ram.we),   64'd0);
        chk("rst cpu_done", 64'(cpu.done), 64'd0);
        chk("rst dbg_done", 64'(dbg.done), 64'd0);
        chk("rst cpu_err",  64'(cpu.err),  64'd0);
        chk("rst stall",    64'(cpu.stall), 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        // 1: CPU read 0x10
        access(1'b0, 1'b0, 64'h10, 64'h0, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t1 lat",    64'(lat),    64'd2);
        chk("t1 rdata",  rd,          64'h10);
        chk("t1 err",    64'(err),    64'd0);
        chk("t1 en cnt", 64'(enCnt),  64'd1);
        chk("t1 addr",   enAddr,      64'h10);
        chk("t1 dbg",    64'(otherDone), 64'd0);

        // 2: CPU write then DBG read-back
        access(1'b0, 1'b1, 64'h20, 64'hDEADBEEF, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t2 wr lat",   64'(lat),    64'd2);
        chk("t2 wr rdata", rd,          64'h0);
        chk("t2 wr we",    64'(weSeen), 64'd1);
        chk("t2 wr addr",  enAddr,      64'h20);
        access(1'b1, 1'b0, 64'h20, 64'h0, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t2 rd lat",   64'(lat),    64'd2);
        chk("t2 rd rdata", rd,          64'hDEADBEEF);
        chk("t2 rd cpu",   64'(otherDone), 64'd0);

        // 4: address boundary
        access(1'b0, 1'b0, 64'h3F9, 64'h0, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t4 3f9 en",    64'(enCnt), 64'd0);
        chk("t4 3f9 err",   64'(err),   64'd1);
        chk("t4 3f9 rdata", rd,         64'h0);
        chk("t4 3f9 lat",   64'(lat),   64'd2);
        access(1'b0, 1'b0, 64'h3F8, 64'h0, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t4 3f8 err",   64'(err),   64'd0);
        chk("t4 3f8 en",    64'(enCnt), 64'd1);
        chk("t4 3f8 rdata", rd,         64'h3F8);
        access(1'b1, 1'b1, 64'h1_0000_0000_0010, 64'h55, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t4 hi err",    64'(err),   64'd1);
        chk("t4 hi en",     64'(enCnt), 64'd0);

        // 5: reset during ACC of a DBG read
        dbg.req = 1'b1; dbg.we = 1'b0; dbg.addr = 64'h20;
        @(negedge clk);
        chk("t5 acc en", 64'(ram.en), 64'd1);
        rstN = 1'b0;
        @(negedge clk);
        chk("t5 en",       64'(ram.en),    64'd0);
        chk("t5 dbg_done", 64'(dbg.done),  64'd0);
        chk("t5 dbg_rd",   dbg.rdata,      64'h0);
        chk("t5 addr",     64'(ram.addr),  64'h0);
        rstN = 1'b1;
        dbg.req = 1'b0; dbg.addr = '0;
        @(negedge clk);
        chk("t5 post done", 64'(dbg.done), 64'd0);
        access(1'b0, 1'b0, 64'h10, 64'h0, rd, err, enCnt, lat, otherDone, enAddr, weSeen);
        chk("t5 cpu lat",   64'(lat), 64'd2);
        chk("t5 cpu rdata", rd,       64'h10);

        // 6: CPU request withdrawn while DBG owns the RAM
        dbg.req = 1'b1; dbg.addr = 64'h20;
        @(negedge clk);
        cpu.req = 1'b1; cpu.addr = 64'h18;
        #1 chk("t6 stall hi", 64'(cpu.stall), 64'd1);
        @(negedge clk);
        chk("t6 dbg done", 64'(dbg.done), 64'd1);
        cpu.req = 1'b0; dbg.req = 1'b0;
        #1 chk("t6 stall lo", 64'(cpu.stall), 64'd0);
        enCnt = 0; otherDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ram.en) enCnt++;
            if (cpu.done) otherDone = 1'b1;
        end
        chk("t6 no en",   64'(enCnt),     64'd0);
        chk("t6 no done", 64'(otherDone), 64'd0);

        // 3: both ports requesting continuously
        begin
            logic [9:0] seq;
            int         n;
            bit         both;
            seq = '0; n = 0; both = 1'b0;
            cpu.req = 1'b1; cpu.addr = 64'h10;
            dbg.req = 1'b1; dbg.addr = 64'h20;
            for (int i = 0; i < 40 && n < 10; i++) begin
                @(negedge clk);
                if (cpu.done && dbg.done) both = 1'b1;
                if (cpu.done) begin seq[n] = 1'b0; n++; end
                else if (dbg.done) begin seq[n] = 1'b1; rd = dbg.rdata; n++; end
            end
            cpu.req = 1'b0; dbg.req = 1'b0;
            chk("t3 count",  64'(n),    64'd10);
            chk("t3 order",  64'(seq),  64'h210);
            chk("t3 both",   64'(both), 64'd0);
            chk("t3 dbg rd", rd,        64'hDEADBEEF);
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
